// File: rtl/oblique_tree_classifier.sv
`default_nettype none
// ============================================================================
// Module  : oblique_tree_classifier
// Brief   : Oblique decision-tree traversal; signed dot product per node.
// Revision: 1.0 - initial release
// ============================================================================
module oblique_tree_classifier #(
  parameter int ATTR_W    = 8,
  parameter int N_ATTR    = 4,
  parameter int COEF_W    = 8,
  parameter int ACC_W     = 20,
  parameter int NODE_AW   = 5,
  parameter int CLASS_W   = 8,
  parameter int MAX_DEPTH = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            cfg_we,
  input  logic [NODE_AW-1:0]                              cfg_addr,
  input  logic [N_ATTR*COEF_W+ACC_W+2*(CLASS_W+1)-1:0]    cfg_wdata,
  input  logic                                            start,
  input  logic [N_ATTR*ATTR_W-1:0]                        attr_in,
  output logic                                            busy,
  output logic                                            done,
  output logic [CLASS_W-1:0]                              class_out,
  output logic                                            err,
  output logic [$clog2(MAX_DEPTH+1)-1:0]                  depth_out
);

  localparam int c_child_w  = CLASS_W + 1;
  localparam int c_node_w   = N_ATTR*COEF_W + ACC_W + 2*c_child_w;
  localparam int c_thr_off  = 2*c_child_w;
  localparam int c_coef_off = 2*c_child_w + ACC_W;
  localparam int c_prod_w   = ATTR_W + COEF_W + 1;
  localparam int c_idx_w    = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
  localparam int c_depth_w  = $clog2(MAX_DEPTH+1);
  localparam int c_mem_d    = 1 << NODE_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_MAC    = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [c_node_w-1:0]      r_mem [c_mem_d];
  logic [c_node_w-1:0]      r_word;
  logic [ATTR_W-1:0]        r_attr [N_ATTR];
  logic [NODE_AW-1:0]       r_node;
  logic [c_idx_w-1:0]       r_idx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [c_depth_w-1:0]     r_depth;

  logic                     w_accept;
  logic signed [COEF_W-1:0] w_coef [N_ATTR];
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_thr;
  logic [c_child_w-1:0]     w_child;
  logic                     w_leaf;
  logic [c_depth_w-1:0]     w_depth_nxt;
  logic                     w_overflow;

  assign w_accept = (r_state == S_IDLE) && start;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

  for (genvar gi = 0; gi < N_ATTR; gi++) begin : g_coef
    assign w_coef[gi] = r_word[c_coef_off + gi*COEF_W +: COEF_W];
  end

  // Attribute is unsigned: zero-extend by one bit before the signed multiply
  assign w_prod      = c_prod_w'(w_coef[r_idx]) * c_prod_w'($signed({1'b0, r_attr[r_idx]}));
  assign w_prod_ext  = ACC_W'(w_prod);
  assign w_thr       = r_word[c_thr_off +: ACC_W];
  assign w_child     = (r_acc <= w_thr) ? r_word[c_child_w +: c_child_w] : r_word[0 +: c_child_w];
  assign w_leaf      = w_child[c_child_w-1];
  assign w_depth_nxt = r_depth + c_depth_w'(1);
  assign w_overflow  = !w_leaf && (w_depth_nxt == c_depth_w'(MAX_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_MAC;
      S_MAC:    if (r_idx == c_idx_w'(N_ATTR-1)) w_state_nxt = S_DECIDE;
      S_DECIDE: w_state_nxt = (w_leaf || w_overflow) ? S_DONE : S_FETCH;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_node    <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_depth   <= '0;
      class_out <= '0;
      err       <= 1'b0;
      depth_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_node    <= '0;
          r_depth   <= '0;
          class_out <= '0;
          err       <= 1'b0;
        end
        S_FETCH: begin
          r_acc <= '0;
          r_idx <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_idx <= r_idx + c_idx_w'(1);
        end
        S_DECIDE: begin
          r_depth <= w_depth_nxt;
          if (w_leaf) begin
            class_out <= w_child[CLASS_W-1:0];
          end else if (w_overflow) begin
            err       <= 1'b1;
            class_out <= '0;
          end else begin
            r_node <= w_child[NODE_AW-1:0];
          end
        end
        S_DONE: depth_out <= r_depth;
        default: ;
      endcase
    end
  end

  // Storage without reset: node contents survive a mid-traversal reset
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && cfg_we) r_mem[cfg_addr] <= cfg_wdata;
    if (w_accept) begin
      for (int i = 0; i < N_ATTR; i++) r_attr[i] <= attr_in[i*ATTR_W +: ATTR_W];
    end
    if (r_state == S_FETCH) r_word <= r_mem[r_node];
  end

endmodule
`default_nettype wire

// File: doc/oblique_tree_classifier.md
# oblique_tree_classifier

Parametrised successor to the decision-diagram accelerator core. It traverses an oblique decision tree stored in an internal node memory, one node at a time. At each node it forms a signed dot product of the latched attribute vector with that node's coefficients, compares the result against the node's threshold, and follows the left or right child. A start/done handshake frames each classification, and an error flag reports traversals that exceed the depth limit. It sits between the host configuration port and the class-result consumer.

## Interface
- ATTR_W, 8, unsigned attribute width
- N_ATTR, 4, attributes per vector (≥1)
- COEF_W, 8, signed coefficient width
- ACC_W, 20, signed accumulator/threshold width
- NODE_AW, 5, node address width (depth 2^NODE_AW)
- CLASS_W, 8, class label width (≥ NODE_AW)
- MAX_DEPTH, 16, max nodes visited per traversal
- Derived: CHILD_W = CLASS_W+1; NODE_W = N_ATTR*COEF_W + ACC_W + 2*CHILD_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  node memory write strobe
- cfg_addr  in  NODE_AW  write address
- cfg_wdata  in  NODE_W  node word
- start  in  1  begin classification (sampled in IDLE only)
- attr_in  in  N_ATTR*ATTR_W  attribute i = attr_in[i*ATTR_W +: ATTR_W], latched on accepted start
- busy  out  1  high from accepted start until the DONE cycle inclusive
- done  out  1  one-cycle pulse, result valid
- class_out  out  CLASS_W  result label, held until next accepted start
- err  out  1  depth limit exceeded, held until next accepted start
- depth_out  out  $clog2(MAX_DEPTH+1)  nodes visited in the last traversal

## Operation
- Node word fields (LSB first): right child [CHILD_W-1:0]; left child [2*CHILD_W-1:CHILD_W]; threshold (signed ACC_W); coef i (signed COEF_W) at offset 2*CHILD_W+ACC_W+i*COEF_W.
- Child field: MSB=1 means leaf, class = low CLASS_W bits. MSB=0 means internal, next node = low NODE_AW bits.
- Node memory: register array, synchronous read, no reset of contents. Writes are accepted only in IDLE; cfg_we outside IDLE is dropped.
- FSM states:
  - IDLE: on start, latch attr_in, node=0, depth=0, clear err/class, go to FETCH.
  - FETCH: register node word, acc=0, idx=0, go to MAC.
  - MAC: N_ATTR cycles. acc += sign-ext($signed(coef[idx]) * $signed({1'b0,attr[idx]})). Product is ATTR_W+COEF_W+1 bits, sign-extended to ACC_W. acc wraps modulo 2^ACC_W. Then go to DECIDE.
  - DECIDE: depth+1. Take left if acc ≤ threshold (signed compare), else right. On a leaf, class_out=label and go to DONE. On an internal child with depth+1 == MAX_DEPTH, set err=1, class_out=0, go to DONE. Otherwise load next node and go to FETCH.
  - DONE: done=1, update depth_out, go to IDLE.
- start outside IDLE is ignored. start and cfg_we together in IDLE: the write commits and start is accepted. The first fetch sees the new word.
- Reset mid-traversal: abort to IDLE with no done pulse. Memory contents are retained.

## Timing
- Reset values: busy=0, done=0, class_out=0, err=0, depth_out=0, state=IDLE.
- Start is sampled at edge 0. Each node costs N_ATTR+2 cycles. done is high in cycle d*(N_ATTR+2)+1, where d = nodes visited. Defaults with d=1 give cycle 7.
- busy rises the cycle after the accepted start and falls the cycle after done.
- A new start may be sampled in the cycle after DONE, giving back-to-back throughput with one IDLE cycle.
- class_out, err and depth_out change only in DECIDE/DONE and on an accepted start.

## Test plan
- Root leaf: node0 coef all 1, thr=10, left=leaf 0x2A; attr {1,2,3,4} (acc=10, equal case) → done at cycle 7, class_out=0x2A, err=0, depth_out=1.
- Two-level right path: same node0 with attr {1,2,3,5} (acc=11) → right=node3. Node3 thr=0, coef0=-1, left=leaf 0x07; → class_out=0x07, done at cycle 13, depth_out=2.
- Negative/extreme: coef=-128, attr=255 on all 4 → acc=-130560. With thr=-130561 → right leaf; with thr=-130560 → left leaf.
- Depth overflow: node0 internal with left=right=node0 → done at cycle 97, err=1, class_out=0, depth_out=16.
- Protocol: start and cfg_we pulsed while busy → no effect on the result and memory unchanged. Write node0 together with start in IDLE → the new word is used.
- Reset mid-MAC: assert rst_n=0 → outputs zero immediately, no done pulse. The next traversal gives the correct result using the retained memory.
